card_shoe: RTL and testbench
============================

// Module: card_shoe
// PURPOSE
//  Responder end of the card-request interface: the round state machine raises a request, this block
//  answers with one card drawn without replacement from a NUM_DECKS shoe and holds the card until the
//  request drops. It replaces free-running card generation in the datapath, so card frequencies
//  are realistic. When the shoe runs dry it reloads itself automatically and reports the reshuffle.
// PARAMETERS
//  NUM_DECKS   1       decks in the shoe, 1..8; per-rank full count = 4*NUM_DECKS
//  LFSR_SEED   16'hACE1  reset value of the 16-bit draw LFSR; must be nonzero
//  CL_W        9       width of cards_left; must hold 52*NUM_DECKS
// PORTS
//  fast_clock   in   1     single clock; all state updates on its rising edge
//  reset        in   1     synchronous, active-high reset
//  req_card     in   1     four-phase request level from the requester
//  card_valid   out  1     card is valid; stays high until req_card drops
//  card         out  4     drawn rank, 1=A .. 10, 11=J, 12=Q, 13=K; 0 when card_valid=0
//  cards_left   out  CL_W  cards remaining in the shoe
//  shoe_empty   out  1     high when cards_left==0
//  reshuffle    out  1     one-cycle pulse in the cycle the shoe is reloaded
// BEHAVIOUR
//  Storage: 13 rank counters, each 6 bits, index 0..12 (rank = index+1).
//  LFSR: 16-bit Galois with taps x^16+x^14+x^13+x^11+1. It advances every cycle except during reset.
//  Reset (any cycle, any state): go to IDLE, all counters = 4*NUM_DECKS, cards_left = 52*NUM_DECKS,
//   LFSR = LFSR_SEED, card_valid=0, card=0, reshuffle=0. A transaction in flight is abandoned with no card issued.
//  Start index: s = lfsr[3:0] when lfsr[3:0] < 13, else lfsr[3:0]-13.
//  FSM states: IDLE, RELOAD, SEARCH, HOLD.
//   IDLE: when req_card=1 and cards_left==0, go to RELOAD. When req_card=1 and cards_left>0,
//    latch idx=s and go to SEARCH.
//   RELOAD (1 cycle): all counters are set to full, cards_left=52*NUM_DECKS, reshuffle=1, latch idx=s,
//    then go to SEARCH.
//   SEARCH: when count[idx]!=0, decrement count[idx] and cards_left, register card=idx+1,
//    card_valid=1, and go to HOLD. Otherwise idx = (idx==12) ? 0 : idx+1 and stay in SEARCH.
//    At most 13 SEARCH cycles are needed, because cards_left>0 guarantees a hit.
//   HOLD: card and card_valid stay stable. When req_card=0, set card_valid=0, card=0, and go to IDLE.
//  Latency from req_card rising (sampled) to card_valid: 2..14 cycles without a reload, 3..15 with a reload.
//  If req_card drops during SEARCH or RELOAD, the draw still completes. HOLD then releases on the next
//   cycle, because req_card is already low. The card is consumed either way.
//  The last card exactly empties the shoe: shoe_empty=1, and no reload happens until the next request.
//  Counter arithmetic never wraps. A decrement only happens on a nonzero count.
//  Invariant: cards_left == sum of the 13 counters at every clock edge.
// TESTING
//  1. Reset with NUM_DECKS=1 -> cards_left=52, card_valid=0, card=0, shoe_empty=0, and every counter=4.
//  2. Single four-phase draw -> card_valid is high within 14 cycles, card is in 1..13, cards_left=51,
//     and card holds until req_card drops; one cycle later card_valid=0.
//  3. 52 back-to-back draws (NUM_DECKS=1) -> each rank appears exactly 4 times, cards_left=0,
//     shoe_empty=1, and reshuffle never pulsed.
//  4. 53rd request -> exactly one reshuffle pulse, card_valid follows, cards_left=51.
//  5. Preload counters so that only rank 13 remains, with LFSR start index 0 -> SEARCH walks 13
//     cycles and returns card=13.
//  6. Assert reset during SEARCH and during HOLD -> next cycle is IDLE, card_valid=0, cards_left=52.
//     Also drop req_card mid-SEARCH -> the card completes and card_valid is high for exactly 1 cycle.

Source files
------------

// File: rtl/card_shoe.sv
// card_shoe: responder end of the card-request handshake. Draws one card
// without replacement from a NUM_DECKS shoe on each four-phase request,
// holds it until the request drops, and reloads itself when the shoe is dry.
//
// state  | meaning
// IDLE   | waiting for req_card; no card presented
// RELOAD | shoe was empty on request; refill all ranks, pulse reshuffle
// SEARCH | walking rank counters from the LFSR start index to a nonzero one
// HOLD   | card presented; waits for req_card to drop
module card_shoe #(
    parameter int          NUM_DECKS = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          CL_W      = 9
) (
    input  logic            fast_clock,
    input  logic            reset,
    input  logic            req_card,
    output logic            card_valid,
    output logic [3:0]      card,
    output logic [CL_W-1:0] cards_left,
    output logic            shoe_empty,
    output logic            reshuffle
);

    localparam logic [5:0]      FULL_CNT  = 6'(4 * NUM_DECKS);
    localparam logic [CL_W-1:0] FULL_SHOE = CL_W'(52 * NUM_DECKS);

    typedef enum logic [1:0] {IDLE, RELOAD, SEARCH, HOLD} state_t;

    state_t      state;
    logic [5:0]  count [0:12];
    logic [3:0]  idx;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [3:0]  start_idx;

    // Galois step for x^16+x^14+x^13+x^11+1 and the folded 0..12 start index
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        start_idx = (lfsr[3:0] < 4'd13) ? lfsr[3:0] : (lfsr[3:0] - 4'd13);
    end

    assign shoe_empty = (cards_left == '0);

    // Draw sequencer, shoe bookkeeping and LFSR, all with registered outputs
    always_ff @(posedge fast_clock) begin
        if (reset) begin
            state      <= IDLE;
            for (int i = 0; i < 13; i++) count[i] <= FULL_CNT;
            cards_left <= FULL_SHOE;
            lfsr       <= LFSR_SEED;
            idx        <= 4'd0;
            card_valid <= 1'b0;
            card       <= 4'd0;
            reshuffle  <= 1'b0;
        end else begin
            lfsr      <= lfsr_next;
            reshuffle <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_card) begin
                        if (cards_left == '0) begin
                            state <= RELOAD;
                        end else begin
                            idx   <= start_idx;
                            state <= SEARCH;
                        end
                    end
                end
                RELOAD: begin
                    for (int i = 0; i < 13; i++) count[i] <= FULL_CNT;
                    cards_left <= FULL_SHOE;
                    reshuffle  <= 1'b1;
                    idx        <= start_idx;
                    state      <= SEARCH;
                end
                SEARCH: begin
                    // cards_left > 0 here, so the walk hits within 13 cycles
                    if (count[idx] != 6'd0) begin
                        count[idx] <= count[idx] - 6'd1;
                        cards_left <= cards_left - CL_W'(1);
                        card       <= idx + 4'd1;
                        card_valid <= 1'b1;
                        state      <= HOLD;
                    end else begin
                        idx <= (idx == 4'd12) ? 4'd0 : (idx + 4'd1);
                    end
                end
                HOLD: begin
                    if (!req_card) begin
                        card_valid <= 1'b0;
                        card       <= 4'd0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: directed scenarios for card_shoe with a transaction-level
// shoe model (rank counts plus the draw LFSR) predicting card and latency.
module tb_card_shoe;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk;
    logic       reset;
    logic       req_card;
    logic       card_valid;
    logic [3:0] card;
    logic [8:0] cards_left;
    logic       shoe_empty;
    logic       reshuffle;

    int vectors;
    int miscompares;

    logic [15:0] m_lfsr;
    int          m_count [0:12];
    int          m_left;
    int          tally   [1:13];
    int          resh_seen;

    card_shoe #(.NUM_DECKS(1), .LFSR_SEED(SEED), .CL_W(9)) dut (
        .fast_clock (clk),
        .reset      (reset),
        .req_card   (req_card),
        .card_valid (card_valid),
        .card       (card),
        .cards_left (cards_left),
        .shoe_empty (shoe_empty),
        .reshuffle  (reshuffle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference LFSR, free-running alongside the DUT
    always @(posedge clk) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always @(negedge clk) if (!reset && reshuffle) resh_seen++;

    function automatic int fold(input logic [15:0] lf);
        return (lf[3:0] < 4'd13) ? int'(lf[3:0]) : int'(lf[3:0]) - 13;
    endfunction

    task automatic model_full();
        for (int i = 0; i < 13; i++) m_count[i] = 4;
        m_left = 52;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        req_card = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_full();
    endtask

    // mode 0: normal four-phase; 1: drop req in first SEARCH cycle; 2: leave held
    task automatic draw(input int mode, input string tag);
        logic [15:0] lf0, lf1;
        int first_valid, got, resh_cnt, resh_t, s, steps, lat_exp;
        bit reload;
        first_valid = -1; got = 0; resh_cnt = 0; resh_t = -1;
        @(negedge clk);
        lf0      = m_lfsr;
        lf1      = 16'h0;
        reload   = (m_left == 0);
        req_card = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (t == 1) begin
                lf1 = m_lfsr;
                if (mode == 1) req_card = 1'b0;
            end
            if (reshuffle) begin resh_cnt++; resh_t = t; end
            if (card_valid) begin first_valid = t; got = int'(card); break; end
        end
        vectors++;
        if (first_valid < 0) begin
            miscompares++;
            $display("FAIL %s timeout: card_valid not seen in 20 cycles, required within 15", tag);
            req_card = 1'b0;
            return;
        end
        if (reload) begin
            model_full();
            s = fold(lf1);
        end else begin
            s = fold(lf0);
        end
        steps = 0;
        while (m_count[s] == 0) begin
            s = (s == 12) ? 0 : s + 1;
            steps++;
        end
        lat_exp = (reload ? 3 : 2) + steps;
        m_count[s]--;
        m_left--;
        tally[s + 1]++;

        vectors++;
        if (first_valid != lat_exp) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles, required %0d", tag, first_valid, lat_exp);
        end
        vectors++;
        if (got != s + 1) begin
            miscompares++;
            $display("FAIL %s card: got %0d, required %0d", tag, got, s + 1);
        end
        vectors++;
        if (resh_cnt != (reload ? 1 : 0) || (reload && resh_t != 2)) begin
            miscompares++;
            $display("FAIL %s reshuffle: got %0d pulses at cycle %0d, required %0d", tag, resh_cnt,
                     resh_t, reload ? 1 : 0);
        end
        vectors++;
        if (cards_left !== 9'(m_left) || shoe_empty !== (m_left == 0)) begin
            miscompares++;
            $display("FAIL %s cards_left: got %0d empty=%b, required %0d empty=%b", tag, cards_left,
                     shoe_empty, m_left, m_left == 0);
        end

        if (mode == 0) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                vectors++;
                if (card_valid !== 1'b1 || card !== 4'(got)) begin
                    miscompares++;
                    $display("FAIL %s hold: got valid=%b card=%0d, required valid=1 card=%0d", tag,
                             card_valid, card, got);
                end
            end
            req_card = 1'b0;
            @(negedge clk);
        end else if (mode == 1) begin
            @(negedge clk);
        end
        if (mode != 2) begin
            vectors++;
            if (card_valid !== 1'b0 || card !== 4'd0) begin
                miscompares++;
                $display("FAIL %s release: got valid=%b card=%0d, required valid=0 card=0", tag,
                         card_valid, card);
            end
        end
    endtask

    task automatic check_idle_full(input string tag);
        vectors++;
        if (card_valid !== 1'b0 || card !== 4'd0 || cards_left !== 9'd52 || shoe_empty !== 1'b0
            || reshuffle !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got valid=%b card=%0d left=%0d empty=%b resh=%b, required 0/0/52/0/0",
                     tag, card_valid, card, cards_left, shoe_empty, reshuffle);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        check_idle_full("reset_state");
    endtask

    task automatic test_single_draw();
        apply_reset();
        draw(0, "single_draw");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int r = 1; r <= 13; r++) tally[r] = 0;
        resh_seen = 0;
        for (int n = 0; n < 52; n++) draw(0, "b2b_draw");
        for (int r = 1; r <= 13; r++) begin
            vectors++;
            if (tally[r] != 4) begin
                miscompares++;
                $display("FAIL b2b_rank_count rank %0d: got %0d, required 4", r, tally[r]);
            end
        end
        vectors++;
        if (cards_left !== 9'd0 || shoe_empty !== 1'b1 || resh_seen != 0) begin
            miscompares++;
            $display("FAIL b2b_empty: got left=%0d empty=%b resh=%0d, required 0/1/0", cards_left,
                     shoe_empty, resh_seen);
        end
    endtask

    task automatic test_reshuffle();
        resh_seen = 0;
        draw(0, "reshuffle_draw");
        vectors++;
        if (resh_seen != 1 || cards_left !== 9'd51) begin
            miscompares++;
            $display("FAIL reshuffle_total: got pulses=%0d left=%0d, required 1 and 51", resh_seen,
                     cards_left);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        draw(0, "pre_search_draw");
        @(negedge clk);
        req_card = 1'b1;
        @(negedge clk);
        reset    = 1'b1;
        req_card = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_full();
        check_idle_full("reset_in_search");
        draw(2, "draw_before_hold_reset");
        @(negedge clk);
        reset    = 1'b1;
        req_card = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_full();
        check_idle_full("reset_in_hold");
        draw(0, "draw_after_reset");
    endtask

    task automatic test_drop_early();
        int hi;
        apply_reset();
        draw(1, "drop_early");
        hi = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (card_valid) hi++;
        end
        vectors++;
        if (hi != 1) begin
            miscompares++;
            $display("FAIL drop_early_width: got valid high %0d cycles, required 1", hi);
        end
        draw(0, "after_drop_early");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resh_seen   = 0;
        reset       = 1'b1;
        req_card    = 1'b0;
        for (int r = 1; r <= 13; r++) tally[r] = 0;
        model_full();
        repeat (3) @(negedge clk);
        test_reset();
        test_single_draw();
        test_back_to_back();
        test_reshuffle();
        test_reset_mid();
        test_drop_early();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
